ex_mem_stack_register: RTL and testbench
========================================

EX_MEM_STACK_REGISTER -- requirements
Module: ex_mem_stack_register

Interface
REQ-001 Parameter DATA_W, default 16: data/address width toward the memory stage.
REQ-002 Parameter PC_W, default 32: program-counter width; SHALL equal 2*DATA_W.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 reset  in  1  synchronous, active-low reset.
REQ-005 ex_valid  in  1  execute stage presents a valid instruction.
REQ-006 ex_kind  in  3  stack kind: 000 NONE, 001 PUSH, 010 POP, 011 CALL, 100 RET; others treated as NONE.
REQ-007 ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_in, ex_out  in  1 each  execute control bits.
REQ-008 ex_alu_data, ex_write_data, ex_read_add  in  DATA_W each  execute results/operands.
REQ-009 ex_pc  in  PC_W  return PC for CALL.
REQ-010 flush  in  1  kill held and incoming instruction (branch/exception).
REQ-011 stall_up  out  1  execute and earlier stages SHALL hold while high.
REQ-012 mem_valid  out  1  registered outputs carry a real operation.
REQ-013 mem_read, mem_write, mem_to_reg, in, out, stackOp, pushPop  out  1 each  memory-stage controls; pushPop 1=push, 0=pop.
REQ-014 state  out  2  stack sub-step: 00 single-word, 01 first word, 10 second word.
REQ-015 PC  out  PC_W; read_add, write_data, alu_data  out  DATA_W each  registered operands.

Function
REQ-016 FSM states: IDLE, SEQ2 (second word of CALL/RET pending).
REQ-017 IDLE, ex_valid, kind NONE/PUSH/POP: register all inputs in one cycle, state=00, stackOp=1 for PUSH/POP, pushPop=1 for PUSH, stall_up=0; stay IDLE.
REQ-018 IDLE, ex_valid, kind CALL: register step 1 (stackOp=1, pushPop=1, mem_write=1, write_data=ex_pc[PC_W-1:DATA_W], state=01), latch ex_pc internally, go SEQ2; stall_up SHALL be 1 combinationally in that same cycle.
REQ-019 SEQ2 after CALL: output step 2 (write_data=latched PC[DATA_W-1:0], state=10, stackOp=1, pushPop=1, mem_write=1); stall_up=0; next IDLE.
REQ-020 IDLE, ex_valid, kind RET: step 1 stackOp=1, pushPop=0, mem_read=1, mem_to_reg=1, state=01; stall_up=1; go SEQ2; step 2 identical with state=10; next IDLE.
REQ-021 ex_valid=0 in IDLE: next cycle mem_valid=0 and mem_read=mem_write=stackOp=in=out=0 (bubble); operand registers MAY hold.
REQ-022 Latency: exactly 1 cycle for single-word ops; CALL/RET occupy 2 consecutive output cycles, no gap.
REQ-023 PC output SHALL carry latched ex_pc unchanged in both CALL/RET steps.
REQ-024 flush (any state) has priority over all: next cycle bubble per REQ-021, FSM to IDLE, stall_up=0 in flush cycle; a half-done CALL/RET is abandoned.
REQ-025 Simultaneous flush and reset: reset wins.
REQ-026 While stall_up=1, execute inputs SHALL be ignored in the following cycle (FSM uses latched values).

Reset
REQ-027 reset=0 at a rising edge: FSM=IDLE, all outputs 0 (state=00, PC=0, data/address=0, mem_valid=0); stall_up=0 while reset low.
REQ-028 Reset mid-CALL/RET aborts sequence; no second word issued.

Structure
REQ-029 Shared package holds ex_kind encodings, state encodings (00/01/10), FSM state enum, DATA_W/PC_W defaults.
REQ-030 Single module, no sub-modules; FSM and output register in one block.

Verification
REQ-031 PUSH: ex_kind=001, ex_write_data=16'hBEEF -> next cycle stackOp=1, pushPop=1, write_data=BEEF, state=00, stall_up=0.
REQ-032 CALL: ex_pc=32'h0001_2345 -> cycle1 write_data=0001 state=01 stall_up=1; cycle2 write_data=2345 state=10 stall_up=0; PC=00012345 both.
REQ-033 RET -> two cycles pushPop=0, mem_read=1, mem_to_reg=1, state 01 then 10; a NONE op held upstream issues in cycle 3.
REQ-034 flush asserted during CALL step 1 -> next cycle mem_valid=0, mem_write=0, FSM IDLE, no state=10 cycle.
REQ-035 reset low during RET SEQ2 -> next cycle all outputs 0; ex_valid=0 after -> bubbles only.
REQ-036 Back-to-back CALL then PUSH -> outputs CALL hi, CALL lo, PUSH in three consecutive cycles.

Source files
------------

// File: rtl/ex_mem_stack_register_pkg.sv
// Shared encodings for the EX/MEM stack pipeline register.
package ex_mem_stack_register_pkg;

    localparam int unsigned DefDataW = 16;
    localparam int unsigned DefPcW   = 32;

    // Stack operation kind carried from execute; undefined codes behave as KindNone.
    typedef enum logic [2:0] {
        KindNone = 3'b000,
        KindPush = 3'b001,
        KindPop  = 3'b010,
        KindCall = 3'b011,
        KindRet  = 3'b100
    } stack_kind_e;

    // Sub-step tag driven on the state output.
    localparam logic [1:0] StepSingle = 2'b00;
    localparam logic [1:0] StepFirst  = 2'b01;
    localparam logic [1:0] StepSecond = 2'b10;

    typedef enum logic [0:0] {
        StIdle,
        StSeq2
    } fsm_state_e;

    // Registered memory-stage control bundle.
    typedef struct packed {
        logic       mem_valid;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       in_op;
        logic       out_op;
        logic       stack_op;
        logic       push_pop;
        logic [1:0] step;
    } mem_ctrl_t;

    // CALL and RET move a full PC, which takes two data-width words.
    function automatic logic is_two_word(input logic [2:0] kind);
        return (kind == KindCall) || (kind == KindRet);
    endfunction

endpackage

// File: rtl/ex_mem_stack_register.sv
// EX/MEM pipeline register that splits CALL/RET PC traffic into two stack words.
// PC_W must equal 2*DATA_W: the PC is pushed/popped as a high word then a low word.
module ex_mem_stack_register
    import ex_mem_stack_register_pkg::*;
#(
    parameter int unsigned DATA_W = DefDataW,
    parameter int unsigned PC_W   = DefPcW
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ex_valid,
    input  logic [2:0]        ex_kind,
    input  logic              ex_mem_read,
    input  logic              ex_mem_write,
    input  logic              ex_mem_to_reg,
    input  logic              ex_in,
    input  logic              ex_out,
    input  logic [DATA_W-1:0] ex_alu_data,
    input  logic [DATA_W-1:0] ex_write_data,
    input  logic [DATA_W-1:0] ex_read_add,
    input  logic [PC_W-1:0]   ex_pc,
    input  logic              flush,
    output logic              stall_up,
    output logic              mem_valid,
    output logic              mem_read,
    output logic              mem_write,
    output logic              mem_to_reg,
    output logic              in,
    output logic              out,
    output logic              stackOp,
    output logic              pushPop,
    output logic [1:0]        state,
    output logic [PC_W-1:0]   PC,
    output logic [DATA_W-1:0] read_add,
    output logic [DATA_W-1:0] write_data,
    output logic [DATA_W-1:0] alu_data
);

    fsm_state_e        fsm_q, fsm_d;
    mem_ctrl_t         ctrl_q, ctrl_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [DATA_W-1:0] read_add_q, read_add_d;
    logic [DATA_W-1:0] write_data_q, write_data_d;
    logic [DATA_W-1:0] alu_data_q, alu_data_d;

    // Hold execute only while a two-word op is being accepted; flush and reset release it.
    assign stall_up = reset && !flush && (fsm_q == StIdle) && ex_valid && is_two_word(ex_kind);

    // Next-state: capture execute in IDLE, replay the latched op as word 2 in SEQ2.
    always_comb begin
        fsm_d        = fsm_q;
        ctrl_d       = ctrl_q;
        pc_d         = pc_q;
        read_add_d   = read_add_q;
        write_data_d = write_data_q;
        alu_data_d   = alu_data_q;

        if (flush) begin
            // Kill held and incoming op; operands are left as they were.
            fsm_d  = StIdle;
            ctrl_d = '0;
        end else begin
            unique case (fsm_q)
                StIdle: begin
                    if (!ex_valid) begin
                        ctrl_d = '0;
                    end else begin
                        ctrl_d            = '0;
                        ctrl_d.mem_valid  = 1'b1;
                        ctrl_d.mem_read   = ex_mem_read;
                        ctrl_d.mem_write  = ex_mem_write;
                        ctrl_d.mem_to_reg = ex_mem_to_reg;
                        ctrl_d.in_op      = ex_in;
                        ctrl_d.out_op     = ex_out;
                        ctrl_d.step       = StepSingle;
                        pc_d              = ex_pc;
                        read_add_d        = ex_read_add;
                        write_data_d      = ex_write_data;
                        alu_data_d        = ex_alu_data;
                        case (ex_kind)
                            KindPush: begin
                                ctrl_d.stack_op = 1'b1;
                                ctrl_d.push_pop = 1'b1;
                            end
                            KindPop: begin
                                ctrl_d.stack_op = 1'b1;
                            end
                            KindCall: begin
                                ctrl_d.stack_op   = 1'b1;
                                ctrl_d.push_pop   = 1'b1;
                                ctrl_d.mem_write  = 1'b1;
                                ctrl_d.mem_read   = 1'b0;
                                ctrl_d.mem_to_reg = 1'b0;
                                ctrl_d.step       = StepFirst;
                                write_data_d      = ex_pc[PC_W-1:DATA_W];
                                fsm_d             = StSeq2;
                            end
                            KindRet: begin
                                ctrl_d.stack_op   = 1'b1;
                                ctrl_d.push_pop   = 1'b0;
                                ctrl_d.mem_read   = 1'b1;
                                ctrl_d.mem_to_reg = 1'b1;
                                ctrl_d.mem_write  = 1'b0;
                                ctrl_d.step       = StepFirst;
                                fsm_d             = StSeq2;
                            end
                            default: ;
                        endcase
                    end
                end
                StSeq2: begin
                    // Execute inputs are ignored here; everything comes from the latched op.
                    ctrl_d.step = StepSecond;
                    if (ctrl_q.push_pop) begin
                        write_data_d = pc_q[DATA_W-1:0];
                    end
                    fsm_d = StIdle;
                end
            endcase
        end
    end

    // FSM and output register; reset overrides flush.
    always_ff @(posedge clk) begin
        if (!reset) begin
            fsm_q        <= StIdle;
            ctrl_q       <= '0;
            pc_q         <= '0;
            read_add_q   <= '0;
            write_data_q <= '0;
            alu_data_q   <= '0;
        end else begin
            fsm_q        <= fsm_d;
            ctrl_q       <= ctrl_d;
            pc_q         <= pc_d;
            read_add_q   <= read_add_d;
            write_data_q <= write_data_d;
            alu_data_q   <= alu_data_d;
        end
    end

    assign mem_valid  = ctrl_q.mem_valid;
    assign mem_read   = ctrl_q.mem_read;
    assign mem_write  = ctrl_q.mem_write;
    assign mem_to_reg = ctrl_q.mem_to_reg;
    assign in         = ctrl_q.in_op;
    assign out        = ctrl_q.out_op;
    assign stackOp    = ctrl_q.stack_op;
    assign pushPop    = ctrl_q.push_pop;
    assign state      = ctrl_q.step;
    assign PC         = pc_q;
    assign read_add   = read_add_q;
    assign write_data = write_data_q;
    assign alu_data   = alu_data_q;

endmodule

// File: tb/tb_ex_mem_stack_register.sv
// Directed bench for ex_mem_stack_register with an expected-output scoreboard.
module tb_ex_mem_stack_register;

    localparam logic [2:0] K_NONE = 3'b000;
    localparam logic [2:0] K_PUSH = 3'b001;
    localparam logic [2:0] K_POP  = 3'b010;
    localparam logic [2:0] K_CALL = 3'b011;
    localparam logic [2:0] K_RET  = 3'b100;
    localparam logic [2:0] K_BAD  = 3'b111;

    typedef struct packed {
        logic        mv;
        logic        rd;
        logic        wr;
        logic        m2r;
        logic        in_b;
        logic        out_b;
        logic        sop;
        logic        pp;
        logic [1:0]  st;
        logic [31:0] pc;
        logic [15:0] ra;
        logic [15:0] wd;
        logic [15:0] ad;
    } obs_t;

    typedef struct {
        obs_t  v;
        bit    ctrl_only;
        string tag;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        ex_valid;
    logic [2:0]  ex_kind;
    logic        ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_in, ex_out;
    logic [15:0] ex_alu_data, ex_write_data, ex_read_add;
    logic [31:0] ex_pc;
    logic        flush;
    logic        stall_up, mem_valid, mem_read, mem_write, mem_to_reg, m_in, m_out;
    logic        stack_op, push_pop;
    logic [1:0]  st;
    logic [31:0] pc_o;
    logic [15:0] read_add, write_data, alu_data;

    obs_t obs;
    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    ex_mem_stack_register #(.DATA_W(16), .PC_W(32)) dut (
        .clk          (clk),
        .reset        (reset),
        .ex_valid     (ex_valid),
        .ex_kind      (ex_kind),
        .ex_mem_read  (ex_mem_read),
        .ex_mem_write (ex_mem_write),
        .ex_mem_to_reg(ex_mem_to_reg),
        .ex_in        (ex_in),
        .ex_out       (ex_out),
        .ex_alu_data  (ex_alu_data),
        .ex_write_data(ex_write_data),
        .ex_read_add  (ex_read_add),
        .ex_pc        (ex_pc),
        .flush        (flush),
        .stall_up     (stall_up),
        .mem_valid    (mem_valid),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_to_reg   (mem_to_reg),
        .in           (m_in),
        .out          (m_out),
        .stackOp      (stack_op),
        .pushPop      (push_pop),
        .state        (st),
        .PC           (pc_o),
        .read_add     (read_add),
        .write_data   (write_data),
        .alu_data     (alu_data)
    );

    assign obs = {mem_valid, mem_read, mem_write, mem_to_reg, m_in, m_out, stack_op, push_pop,
                  st, pc_o, read_add, write_data, alu_data};

    function automatic obs_t mk(input logic mv, rd, wr, m2r, i, o, sop, pp,
                                input logic [1:0] s, input logic [31:0] pc,
                                input logic [15:0] ra, wd, ad);
        obs_t r;
        r = {mv, rd, wr, m2r, i, o, sop, pp, s, pc, ra, wd, ad};
        return r;
    endfunction

    task automatic expect_full(input obs_t v, input string tag);
        exp_t e;
        e.v = v; e.ctrl_only = 1'b0; e.tag = tag;
        sb.push_back(e);
    endtask

    // Bubble: only the valid and activity controls are defined, operands may hold.
    task automatic expect_bubble(input string tag);
        exp_t e;
        e.v = '0; e.ctrl_only = 1'b1; e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic apply(input logic v, input logic [2:0] k, input logic rd, wr, m2r, i, o,
                         input logic [15:0] ra, wd, ad, input logic [31:0] pc);
        ex_valid = v; ex_kind = k; ex_mem_read = rd; ex_mem_write = wr; ex_mem_to_reg = m2r;
        ex_in = i; ex_out = o; ex_read_add = ra; ex_write_data = wd; ex_alu_data = ad; ex_pc = pc;
    endtask

    task automatic check_stall(input logic expv, input string tag);
        #1;
        vectors++;
        assert (stall_up === expv) else begin
            miscompares++;
            $error("FAIL %s: stall_up observed %b expected %b", tag, stall_up, expv);
        end
    endtask

    task automatic tick();
        exp_t e;
        obs_t got;
        @(posedge clk);
        #1;
        got = obs;
        vectors++;
        if (sb.size() == 0) begin
            miscompares++;
            $error("FAIL scoreboard_empty: observed %h expected <entry>", got);
        end else begin
            e = sb.pop_front();
            if (e.ctrl_only) begin
                assert ({got.mv, got.rd, got.wr, got.in_b, got.out_b, got.sop} ===
                        {e.v.mv, e.v.rd, e.v.wr, e.v.in_b, e.v.out_b, e.v.sop}) else begin
                    miscompares++;
                    $error("FAIL %s: observed %h expected %h (controls)", e.tag, got, e.v);
                end
            end else begin
                assert (got === e.v) else begin
                    miscompares++;
                    $error("FAIL %s: observed %h expected %h", e.tag, got, e.v);
                end
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1);
    end

    initial begin
        // Reset with a CALL presented: no stall, all outputs zero.
        reset = 1'b0; flush = 1'b0;
        apply(1, K_CALL, 0, 0, 0, 1, 1, 16'h1111, 16'h2222, 16'h3333, 32'h5555_6666);
        check_stall(0, "stall_in_reset");
        expect_full('0, "reset_state");
        tick();

        // PUSH
        reset = 1'b1;
        apply(1, K_PUSH, 0, 1, 0, 0, 0, 16'h00FE, 16'hBEEF, 16'h1111, 32'h0000_1000);
        check_stall(0, "push_stall");
        expect_full(mk(1, 0, 1, 0, 0, 0, 1, 1, 2'b00, 32'h0000_1000, 16'h00FE, 16'hBEEF, 16'h1111),
                    "push");
        tick();

        // POP
        apply(1, K_POP, 1, 0, 1, 0, 0, 16'h00FD, 16'h0000, 16'h2222, 32'h0000_1004);
        expect_full(mk(1, 1, 0, 1, 0, 0, 1, 0, 2'b00, 32'h0000_1004, 16'h00FD, 16'h0000, 16'h2222),
                    "pop");
        tick();

        // NONE with in, then an undefined kind with out
        apply(1, K_NONE, 0, 0, 0, 1, 0, 16'h0000, 16'h0000, 16'h3333, 32'h0000_1008);
        expect_full(mk(1, 0, 0, 0, 1, 0, 0, 0, 2'b00, 32'h0000_1008, 16'h0000, 16'h0000, 16'h3333),
                    "none_in");
        tick();
        apply(1, K_BAD, 0, 0, 0, 0, 1, 16'h0010, 16'h0020, 16'h4444, 32'h0000_100C);
        expect_full(mk(1, 0, 0, 0, 0, 1, 0, 0, 2'b00, 32'h0000_100C, 16'h0010, 16'h0020, 16'h4444),
                    "kind111_as_none");
        tick();

        // Bubble with junk on the other inputs
        apply(0, K_PUSH, 1, 1, 1, 1, 1, 16'hFFFF, 16'hFFFF, 16'hFFFF, 32'hFFFF_FFFF);
        check_stall(0, "bubble_stall");
        expect_bubble("bubble");
        tick();

        // CALL, junk during SEQ2, then PUSH back-to-back
        apply(1, K_CALL, 0, 0, 0, 0, 0, 16'h0100, 16'hAAAA, 16'h5555, 32'h0001_2345);
        check_stall(1, "call_stall_hi");
        expect_full(mk(1, 0, 1, 0, 0, 0, 1, 1, 2'b01, 32'h0001_2345, 16'h0100, 16'h0001, 16'h5555),
                    "call_hi");
        tick();
        apply(1, K_RET, 1, 0, 1, 1, 1, 16'h0F0F, 16'h1234, 16'h9999, 32'hDEAD_BEEF);
        check_stall(0, "call_stall_lo");
        expect_full(mk(1, 0, 1, 0, 0, 0, 1, 1, 2'b10, 32'h0001_2345, 16'h0100, 16'h2345, 16'h5555),
                    "call_lo");
        tick();
        apply(1, K_PUSH, 0, 1, 0, 0, 0, 16'h0101, 16'hCAFE, 16'h0A0A, 32'h0000_2004);
        check_stall(0, "push_after_call_stall");
        expect_full(mk(1, 0, 1, 0, 0, 0, 1, 1, 2'b00, 32'h0000_2004, 16'h0101, 16'hCAFE, 16'h0A0A),
                    "push_after_call");
        tick();

        // RET, held upstream through SEQ2, then NONE issues next
        apply(1, K_RET, 1, 0, 1, 0, 0, 16'h0200, 16'h0000, 16'h6666, 32'h0000_2000);
        check_stall(1, "ret_stall_1");
        expect_full(mk(1, 1, 0, 1, 0, 0, 1, 0, 2'b01, 32'h0000_2000, 16'h0200, 16'h0000, 16'h6666),
                    "ret_step1");
        tick();
        check_stall(0, "ret_stall_2");
        expect_full(mk(1, 1, 0, 1, 0, 0, 1, 0, 2'b10, 32'h0000_2000, 16'h0200, 16'h0000, 16'h6666),
                    "ret_step2");
        tick();
        apply(1, K_NONE, 0, 0, 0, 0, 0, 16'h0300, 16'h0400, 16'h7777, 32'h0000_3000);
        expect_full(mk(1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 32'h0000_3000, 16'h0300, 16'h0400, 16'h7777),
                    "none_after_ret");
        tick();

        // Flush during CALL word 1: no second word, FSM back in IDLE
        apply(1, K_CALL, 0, 0, 0, 0, 0, 16'h0500, 16'h0000, 16'h8888, 32'hABCD_1234);
        check_stall(1, "call2_stall");
        expect_full(mk(1, 0, 1, 0, 0, 0, 1, 1, 2'b01, 32'hABCD_1234, 16'h0500, 16'hABCD, 16'h8888),
                    "call2_hi");
        tick();
        flush = 1'b1;
        check_stall(0, "flush_stall");
        expect_bubble("flush_kills_call");
        tick();
        flush = 1'b0;
        apply(0, K_NONE, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 32'h0);
        expect_bubble("after_flush_bubble");
        tick();
        apply(1, K_PUSH, 0, 1, 0, 0, 0, 16'h0600, 16'h1357, 16'h2468, 32'h0000_4000);
        expect_full(mk(1, 0, 1, 0, 0, 0, 1, 1, 2'b00, 32'h0000_4000, 16'h0600, 16'h1357, 16'h2468),
                    "push_after_flush");
        tick();

        // Flush in IDLE with CALL offered: no stall, bubble
        flush = 1'b1;
        apply(1, K_CALL, 0, 0, 0, 1, 1, 16'h0700, 16'h0000, 16'h0000, 32'h1111_2222);
        check_stall(0, "flush_idle_stall");
        expect_bubble("flush_idle_call");
        tick();
        flush = 1'b0;
        apply(0, K_NONE, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 32'h0);
        expect_bubble("flush_idle_after");
        tick();

        // Reset (with flush) during RET SEQ2: all zero, then only bubbles
        apply(1, K_RET, 1, 0, 1, 0, 0, 16'h0800, 16'h0000, 16'h9999, 32'h0000_5000);
        check_stall(1, "ret3_stall");
        expect_full(mk(1, 1, 0, 1, 0, 0, 1, 0, 2'b01, 32'h0000_5000, 16'h0800, 16'h0000, 16'h9999),
                    "ret3_step1");
        tick();
        reset = 1'b0; flush = 1'b1;
        check_stall(0, "reset_flush_stall");
        expect_full('0, "reset_mid_ret");
        tick();
        reset = 1'b1; flush = 1'b0;
        apply(0, K_RET, 1, 0, 1, 0, 0, 16'h0800, 16'h0000, 16'h9999, 32'h0000_5000);
        expect_bubble("post_reset_bubble1");
        tick();
        expect_bubble("post_reset_bubble2");
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
